// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - single-slot instruction fetch stage with redirect; optional FETCH_MISALIGN_TRAP_EN
module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic [31:0] out_pc_plus4,
  output logic [31:0] fetch_count
`ifdef FETCH_MISALIGN_TRAP_EN
  ,
  output logic        misalign_err
`endif
);

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [31:0] pc;
  logic [31:0] pc_nxt;
  logic        valid_nxt;
  logic [31:0] instr_nxt;
  logic [31:0] opc_nxt;
  logic [31:0] opc4_nxt;
  logic [31:0] count_nxt;
  logic        handoff;
  logic [31:0] target_load;

`ifdef FETCH_MISALIGN_TRAP_EN
  logic        err_nxt;
  logic        misaligned;

  assign misaligned  = (redirect_target[1:0] != 2'b00);
  assign target_load = redirect_target;
`else
  // Without the trap, a misaligned target is silently word-aligned.
  assign target_load = redirect_target & 32'hFFFF_FFFC;
`endif

  assign imem_addr = pc;
  // A handoff completes whenever the slot is offered and accepted, even on a redirect edge.
  assign handoff   = out_valid & out_ready;

  // Next-state and next-register computation for the fetch FSM.
  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    valid_nxt = out_valid;
    instr_nxt = out_instr;
    opc_nxt   = out_pc;
    opc4_nxt  = out_pc_plus4;
    count_nxt = fetch_count + {31'd0, handoff};
`ifdef FETCH_MISALIGN_TRAP_EN
    err_nxt   = misalign_err;
`endif
    case (state)
      BOOT: begin
        // No capture yet; a redirect may still retarget the first fetch.
        state_nxt = RUN;
        valid_nxt = 1'b0;
        if (redirect_valid) begin
`ifdef FETCH_MISALIGN_TRAP_EN
          if (misaligned) err_nxt = 1'b1;
          else
`endif
          pc_nxt = target_load;
        end
      end
      RUN: begin
        if (redirect_valid) begin
          valid_nxt = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
          if (misaligned) begin
            err_nxt   = 1'b1;
            state_nxt = HALT;
          end else
`endif
          pc_nxt = target_load;
        end else if (!out_valid || out_ready) begin
          valid_nxt = 1'b1;
          instr_nxt = imem_data;
          opc_nxt   = pc;
          opc4_nxt  = pc + 32'd4;
          pc_nxt    = pc + 32'd4;
        end
      end
      HALT: begin
        valid_nxt = 1'b0;
      end
      default: begin
        state_nxt = BOOT;
        valid_nxt = 1'b0;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= BOOT;
      pc           <= RESET_PC;
      out_valid    <= 1'b0;
      out_instr    <= 32'd0;
      out_pc       <= 32'd0;
      out_pc_plus4 <= 32'd0;
      fetch_count  <= 32'd0;
`ifdef FETCH_MISALIGN_TRAP_EN
      misalign_err <= 1'b0;
`endif
    end else begin
      state        <= state_nxt;
      pc           <= pc_nxt;
      out_valid    <= valid_nxt;
      out_instr    <= instr_nxt;
      out_pc       <= opc_nxt;
      out_pc_plus4 <= opc4_nxt;
      fetch_count  <= count_nxt;
`ifdef FETCH_MISALIGN_TRAP_EN
      misalign_err <= err_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// tb/tb_instr_fetch.sv - directed scoreboard bench for instr_fetch
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic [31:0] out_pc_plus4;
  logic [31:0] fetch_count;
`ifdef FETCH_MISALIGN_TRAP_EN
  logic        misalign_err;
`endif

  int          tests = 0;
  int          fails = 0;
  int          fc_exp = 0;
  logic [31:0] sb[$];

  always #5 clk = ~clk;

  function automatic logic [31:0] rom(input logic [31:0] a);
    if (a == 32'd0) return 32'h002080B3;
    return (a ^ 32'h5A5A_0000) + 32'h0000_0013;
  endfunction

  assign imem_data = rom(imem_addr);

  instr_fetch #(.RESET_PC(32'h0000_0000)) dut (
    .clk            (clk),
    .reset          (reset),
    .imem_addr      (imem_addr),
    .imem_data      (imem_data),
    .redirect_valid (redirect_valid),
    .redirect_target(redirect_target),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc         (out_pc),
    .out_pc_plus4   (out_pc_plus4),
    .fetch_count    (fetch_count)
`ifdef FETCH_MISALIGN_TRAP_EN
    ,
    .misalign_err   (misalign_err)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: at the negedge a pending handoff is scored, then advance past the posedge.
  task automatic tick();
    logic [31:0] p;
    @(negedge clk);
    if (out_valid && out_ready) begin
      if (sb.size() == 0) begin
        chk("sb_underflow", out_pc, 32'hXXXX_XXXX);
      end else begin
        p = sb.pop_front();
        chk("ho_pc", out_pc, p);
        chk("ho_instr", out_instr, rom(p));
        chk("ho_pc4", out_pc_plus4, p + 32'd4);
      end
      fc_exp++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_valid"}, {31'd0, out_valid}, 32'd0);
    chk({tag, "_instr"}, out_instr, 32'd0);
    chk({tag, "_pc"}, out_pc, 32'd0);
    chk({tag, "_pc4"}, out_pc_plus4, 32'd0);
    chk({tag, "_count"}, fetch_count, 32'd0);
    chk({tag, "_addr"}, imem_addr, 32'h0000_0000);
`ifdef FETCH_MISALIGN_TRAP_EN
    chk({tag, "_err"}, {31'd0, misalign_err}, 32'd0);
`endif
  endtask

  initial begin
    reset = 1'b1;
    out_ready = 1'b1;
    redirect_valid = 1'b0;
    redirect_target = 32'd0;
    @(posedge clk);
    @(posedge clk);
    #1;
    chk_reset_vals("rst0");
    reset = 1'b0;
    for (int i = 0; i < 8; i++) sb.push_back(32'(i * 4));

    // Boot cycle, then first capture and streaming.
    tick();
    chk("boot_valid", {31'd0, out_valid}, 32'd0);
    tick();
    chk("first_valid", {31'd0, out_valid}, 32'd1);
    chk("first_pc", out_pc, 32'd0);
    chk("first_instr", out_instr, 32'h002080B3);
    chk("first_addr", imem_addr, 32'd4);
    tick();
    chk("s1_pc", out_pc, 32'd4);
    chk("s1_count", fetch_count, 32'd1);
    tick();
    chk("s2_pc", out_pc, 32'd8);
    chk("s2_count", fetch_count, 32'd2);

    // Stall with slot holding pc 8.
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_pc", out_pc, 32'd8);
      chk("stall_instr", out_instr, rom(32'd8));
      chk("stall_addr", imem_addr, 32'd12);
      chk("stall_count", fetch_count, 32'd2);
    end
    out_ready = 1'b1;
    tick();
    chk("rel_pc", out_pc, 32'd12);
    chk("rel_count", fetch_count, 32'd3);

    // Redirect concurrent with handoff.
    redirect_valid = 1'b1;
    redirect_target = 32'h20;
    tick();
    redirect_valid = 1'b0;
    sb.delete();
    sb.push_back(32'h20);
    sb.push_back(32'h24);
    sb.push_back(32'h28);
    chk("rd_count", fetch_count, 32'd4);
    chk("rd_valid", {31'd0, out_valid}, 32'd0);
    chk("rd_addr", imem_addr, 32'h20);
    tick();
    chk("rd_pc", out_pc, 32'h20);
    chk("rd_pc4", out_pc_plus4, 32'h24);
    chk("rd_valid2", {31'd0, out_valid}, 32'd1);
    tick();
    chk("rd_next_pc", out_pc, 32'h24);
    chk("model_count", fetch_count, 32'(fc_exp));

    // Wrap at the top of the address space.
    redirect_valid = 1'b1;
    redirect_target = 32'hFFFF_FFFC;
    tick();
    redirect_valid = 1'b0;
    sb.delete();
    sb.push_back(32'hFFFF_FFFC);
    sb.push_back(32'h0);
    sb.push_back(32'h4);
    tick();
    chk("wrap_pc", out_pc, 32'hFFFF_FFFC);
    chk("wrap_pc4", out_pc_plus4, 32'h0);
    tick();
    chk("wrap_next_pc", out_pc, 32'h0);
    chk("wrap_addr", imem_addr, 32'h4);

    // Misaligned redirect.
    redirect_valid = 1'b1;
    redirect_target = 32'h22;
    tick();
    sb.delete();
`ifdef FETCH_MISALIGN_TRAP_EN
    chk("mis_err", {31'd0, misalign_err}, 32'd1);
    chk("mis_valid", {31'd0, out_valid}, 32'd0);
    chk("mis_addr", imem_addr, 32'h4);
    redirect_target = 32'h40;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("halt_addr", imem_addr, 32'h4);
      chk("halt_valid", {31'd0, out_valid}, 32'd0);
      chk("halt_err", {31'd0, misalign_err}, 32'd1);
    end
    redirect_valid = 1'b0;
`else
    redirect_valid = 1'b0;
    sb.push_back(32'h20);
    sb.push_back(32'h24);
    tick();
    chk("mis_pc", out_pc, 32'h20);
    chk("mis_addr", imem_addr, 32'h24);
`endif

    // Reset, stream five handoffs, stall, then reset mid-stall and mid-redirect.
    out_ready = 1'b0;
    reset = 1'b1;
    tick();
    chk_reset_vals("rst1");
    reset = 1'b0;
    out_ready = 1'b1;
    sb.delete();
    fc_exp = 0;
    for (int i = 0; i < 8; i++) sb.push_back(32'(i * 4));
    tick();
    tick();
    for (int i = 0; i < 5; i++) tick();
    chk("five_count", fetch_count, 32'd5);
    chk("five_model", fetch_count, 32'(fc_exp));
    out_ready = 1'b0;
    tick();
    chk("five_stall_pc", out_pc, 32'h14);
    reset = 1'b1;
    redirect_valid = 1'b1;
    redirect_target = 32'h80;
    tick();
    chk_reset_vals("rst2");
    reset = 1'b0;
    redirect_valid = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Clock and reset: one clock `clk`; reset `reset` is synchronous and active-high.
REQ-002 Parameter: RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 reset  input  1  synchronous, active-high; sampled on rising `clk`.
REQ-005 imem_addr  output  32  byte address to the combinational instruction ROM; always equals the internal PC register.
REQ-006 imem_data  input  32  instruction word returned combinationally for imem_addr.
REQ-007 redirect_valid  input  1  branch/jump redirect request, one cycle.
REQ-008 redirect_target  input  32  redirect byte address.
REQ-009 out_valid  output  1  fetched-instruction slot holds a valid entry.
REQ-010 out_ready  input  1  downstream decode accepts the slot.
REQ-011 out_instr  output  32  fetched instruction word.
REQ-012 out_pc  output  32  address of out_instr.
REQ-013 out_pc_plus4  output  32  out_pc + 4, modulo 2^32.
REQ-014 fetch_count  output  32  number of completed handoffs (out_valid & out_ready).
REQ-015 misalign_err  output  1  sticky misaligned-redirect flag; present only with FETCH_MISALIGN_TRAP_EN.

Function
REQ-016 FSM states: BOOT, RUN, HALT; BOOT->RUN unconditionally after one cycle; RUN->HALT only per REQ-027; HALT is left only by reset.
REQ-017 In BOOT, no capture; out_valid=0; a redirect in BOOT loads the PC per REQ-021.
REQ-018 Capture condition in RUN: slot free (out_valid=0) or handoff (out_valid & out_ready), and redirect_valid=0.
REQ-019 On capture: out_instr<=imem_data, out_pc<=PC, out_pc_plus4<=PC+4, out_valid<=1, PC<=PC+4; latency one cycle from imem_addr to out_* valid.
REQ-020 Stall (out_valid=1, out_ready=0, no redirect): PC and all out_* hold their values.
REQ-021 Redirect has priority over capture and stall: PC<=redirect_target, out_valid<=0 at the same edge; the first instruction from the target appears on out_* two edges after redirect.
REQ-022 Redirect concurrent with handoff: the handoff completes (fetch_count increments) and the slot is still cleared.
REQ-023 PC arithmetic is 32-bit; 0xFFFF_FFFC+4 wraps to 0x0000_0000 with no flag.
REQ-024 fetch_count increments by 1 on each handoff edge and wraps from 0xFFFF_FFFF to 0.
REQ-025 In HALT: no capture, out_valid=0, PC frozen, further redirects ignored.

Reset
REQ-026 On a reset edge, in any state and mid-stall or mid-redirect: PC=RESET_PC, state=BOOT, out_valid=0, out_instr=0, out_pc=0, out_pc_plus4=0, fetch_count=0, misalign_err=0; imem_addr=RESET_PC the following cycle.

Configuration
REQ-027 With FETCH_MISALIGN_TRAP_EN defined, a redirect with target[1:0]!=0:
- sets misalign_err=1 (sticky);
- leaves PC unchanged;
- clears out_valid;
- enters HALT.
REQ-028 Without FETCH_MISALIGN_TRAP_EN, the misalign_err port is absent, HALT is unreachable, and redirect_target[1:0] is forced to 2'b00 before loading the PC.

Verification
REQ-029 Reset, RESET_PC=0, out_ready=1, ROM word0=0x002080B3 -> BOOT cycle out_valid=0; next edge out_valid=1, out_pc=0, out_instr=0x002080B3; then out_pc 4, 8, 12 on consecutive edges; fetch_count counts up 1, 2, 3.
REQ-030 Slot holding out_pc=8, out_ready=0 held for 3 cycles -> out_pc=8, out_instr stable, imem_addr=12 throughout, fetch_count unchanged; release -> out_pc=12 next edge.
REQ-031 redirect_valid=1, target=0x20, pulsed while out_valid=1 and out_ready=1 -> fetch_count +1, next cycle out_valid=0 and imem_addr=0x20, following edge out_pc=0x20, out_pc_plus4=0x24.
REQ-032 Redirect to 0xFFFF_FFFC -> out_pc=0xFFFF_FFFC with out_pc_plus4=0x0, then out_pc=0x0000_0000.
REQ-033 Redirect to 0x22: with the macro -> misalign_err=1, out_valid=0, imem_addr unchanged permanently until reset; without the macro -> out_pc=0x20.
REQ-034 Reset asserted during a stall with fetch_count=5 -> next edge: all outputs at REQ-026 values, imem_addr=RESET_PC.
